// File: rtl/quad_position_counter_if.sv
// quad_position_counter_if: step/control inputs and position/speed outputs of the counter.
// Latency: n/a (wiring only).
// Backpressure: none; the counter accepts one step per clk with no stall.
// Ports (master = producer of steps and controls, slave = counter):
//   cnt_en, dir, clear, load, load_val            master -> slave
//   position, wrap_up, wrap_dn, speed,
//   speed_valid, spd_sat                          slave -> master
interface quad_position_counter_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 16
) ();
  logic             cnt_en;
  logic             dir;
  logic             clear;
  logic             load;
  logic [POS_W-1:0] load_val;
  logic [POS_W-1:0] position;
  logic             wrap_up;
  logic             wrap_dn;
  logic [SPD_W-1:0] speed;
  logic             speed_valid;
  logic             spd_sat;

  modport master (
    output cnt_en, dir, clear, load, load_val,
    input  position, wrap_up, wrap_dn, speed, speed_valid, spd_sat
  );

  modport slave (
    input  cnt_en, dir, clear, load, load_val,
    output position, wrap_up, wrap_dn, speed, speed_valid, spd_sat
  );
endinterface

// File: rtl/quad_position_counter.sv
// quad_position_counter: wrap-around position count plus signed net-steps-per-window speed.
// Latency: 1 clk from step/clear/load to position and wrap pulses; speed lands 1 clk after the terminal gate cycle.
// Backpressure: none; every cnt_en cycle is a step, back-to-back steps all count.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   bus (slave)   cnt_en/dir step strobe, clear/load/load_val position controls;
//                 position, wrap_up/wrap_dn pulses, speed/speed_valid/spd_sat window result
module quad_position_counter #(
  parameter int POS_W       = 16,
  parameter int SPD_W       = 16,
  parameter int GATE_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  quad_position_counter_if.slave        bus
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [POS_W-1:0] POS_MAX   = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [SPD_W-1:0] SPD_MAX   = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic [SPD_W-1:0] SPD_MIN   = {1'b1, {(SPD_W-1){1'b0}}};
  localparam logic [SPD_W-1:0] SPD_ONE   = SPD_W'(1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);

  logic [POS_W-1:0] position;
  logic             wrap_up;
  logic             wrap_dn;
  logic [SPD_W-1:0] speed;
  logic             speed_valid;
  logic             spd_sat;

  logic [SPD_W-1:0] acc;
  logic [SPD_W-1:0] acc_nx;
  logic             sat_now;
  logic             win_sat;
  logic [GW-1:0]    gate;
  logic             terminal;
  logic             step_only;

  // Only a step that actually moves the position may produce a wrap pulse.
  assign step_only = bus.cnt_en & ~bus.clear & ~bus.load;
  assign terminal  = (gate == GATE_LAST);

  // Saturating accumulator update; the accumulator sees every step,
  // including ones that clear/load drop from the position.
  always_comb begin
    acc_nx  = acc;
    sat_now = 1'b0;
    if (bus.cnt_en) begin
      if (bus.dir) begin
        if (acc == SPD_MAX) sat_now = 1'b1;
        else                acc_nx  = acc + SPD_ONE;
      end else begin
        if (acc == SPD_MIN) sat_now = 1'b1;
        else                acc_nx  = acc - SPD_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      position    <= '0;
      wrap_up     <= 1'b0;
      wrap_dn     <= 1'b0;
      speed       <= '0;
      speed_valid <= 1'b0;
      spd_sat     <= 1'b0;
      acc         <= '0;
      win_sat     <= 1'b0;
      gate        <= '0;
    end else begin
      wrap_up <= step_only &  bus.dir & (position == POS_MAX);
      wrap_dn <= step_only & ~bus.dir & (position == '0);

      if (bus.clear)       position <= '0;
      else if (bus.load)   position <= bus.load_val;
      else if (bus.cnt_en) position <= bus.dir ? position + POS_ONE : position - POS_ONE;

      speed_valid <= terminal;
      if (terminal) begin
        // Terminal cycle's own step is folded into the published result.
        speed   <= acc_nx;
        spd_sat <= win_sat | sat_now;
        acc     <= '0;
        win_sat <= 1'b0;
        gate    <= '0;
      end else begin
        acc     <= acc_nx;
        win_sat <= win_sat | sat_now;
        gate    <= gate + GATE_ONE;
      end
    end
  end

  assign bus.position    = position;
  assign bus.wrap_up     = wrap_up;
  assign bus.wrap_dn     = wrap_dn;
  assign bus.speed       = speed;
  assign bus.speed_valid = speed_valid;
  assign bus.spd_sat     = spd_sat;

endmodule
